// File: rtl/alu_result_sequencer.sv
// alu_result_sequencer: drives the select lines of a bit-sliced 5-input
// result mux, waits for the slices to settle, then captures the result and
// adder flags and holds them for a valid/ready consumer.
module alu_result_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  output logic [2:0]       mux_sel,
  input  logic [WIDTH-1:0] mux_result,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_carry,
  output logic             res_overflow,
  output logic             res_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_t;

  // Counter reload: the edge that sees zero is the capture edge, so a hold
  // of N cycles needs N-1 decrement edges first.
  localparam logic [7:0] LP_CNT_INIT = 8'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic             r_err;

  logic             w_accept;
  logic             w_legal;
  logic             w_capture;
  logic             w_flags_op;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_legal    = (cmd_op <= 3'd4);
  assign w_capture  = (r_state == ST_SETTLE) && (r_cnt == 8'd0);
  // Only add/sub (ops 0,1) route through the adder slice, so only they own the flags.
  assign w_flags_op = (r_sel <= 3'd1);

  assign mux_sel      = r_sel;
  assign res_data     = r_data;
  assign res_zero     = r_zero;
  assign res_carry    = r_carry;
  assign res_overflow = r_ovf;
  assign res_err      = r_err;

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = !reset;
        if (w_accept) w_state_nxt = w_legal ? ST_SETTLE : ST_RESP;
      end
      ST_SETTLE: begin
        if (r_cnt == 8'd0) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Select lines and settle counter; select is frozen outside IDLE and on
  // illegal ops so the mux keeps driving the last legal selection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel <= 3'd0;
      r_cnt <= 8'd0;
    end else if (w_accept && w_legal) begin
      r_sel <= cmd_op;
      r_cnt <= LP_CNT_INIT;
    end else if (r_state == ST_SETTLE && r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  // Result capture; values persist until the next capture or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b1;
    end else if (w_capture) begin
      r_data  <= mux_result;
      r_zero  <= (mux_result == '0);
      r_carry <= w_flags_op && alu_carryout;
      r_ovf   <= w_flags_op && alu_overflow;
      r_err   <= 1'b0;
    end
  end

endmodule
